// File: rtl/fact_pkg.sv
// Shared types for the factorial engine and its job controller.
// Reused by the engine bench and any other consumer of the factorial path.
package fact_pkg;

   localparam int FACT_MAX_N = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fact_state_e;

   typedef struct packed {
      logic ovf;
      logic err;
   } fact_status_t;

endpackage

// File: rtl/fact_watchdog.sv
// Cycle counter that aborts a job whose engine never reports done.
// expire_o is high for the single enabled cycle in which the count reaches TIMEOUT-1.
module fact_watchdog #(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fact_job_ctrl.sv
// Job controller in front of the iterative factorial engine: accepts (n, tag), loads the
// engine, and returns the result, handling n==0, n>MAX_N and a hung engine itself.
module fact_job_ctrl
   import fact_pkg::*;
#(
   parameter int N_W     = 4,
   parameter int D_W     = 32,
   parameter int TAG_W   = 4,
   parameter int MAX_N   = FACT_MAX_N,
   parameter int TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [N_W-1:0]   s_n,
   input  logic [TAG_W-1:0] s_tag,
   output logic             fe_load,
   output logic [N_W-1:0]   fe_n,
   input  logic [D_W-1:0]   fe_data,
   input  logic             fe_valid,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [D_W-1:0]   m_data,
   output logic [TAG_W-1:0] m_tag,
   output logic             m_ovf,
   output logic             m_err,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready; valid
   // never depends on ready, and every output decodes registered state only.

   fact_state_e  state_q, state_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [D_W-1:0]   data_q, data_d;
   fact_status_t     status_q, status_d;
   logic             wd_clr;
   logic             wd_en;
   logic             wd_expire;

   fact_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rstn     (rstn),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      tag_d    = tag_q;
      data_d   = data_q;
      status_d = status_q;
      wd_clr   = 1'b0;
      wd_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_valid) begin
               n_d      = s_n;
               tag_d    = s_tag;
               data_d   = '0;
               status_d = '0;
               // The engine never completes for n==0, so 0! is answered locally.
               if (s_n == '0) begin
                  data_d  = D_W'(1);
                  state_d = HOLD;
               end else if (32'(s_n) > 32'(MAX_N)) begin
                  status_d.ovf = 1'b1;
                  state_d      = HOLD;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            wd_clr  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (fe_valid) begin
               data_d  = fe_data;
               state_d = HOLD;
            end else begin
               wd_en = 1'b1;
               if (wd_expire) begin
                  data_d       = '0;
                  status_d.err = 1'b1;
                  state_d      = HOLD;
               end
            end
         end
         HOLD: begin
            if (m_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         n_q      <= '0;
         tag_q    <= '0;
         data_q   <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         tag_q    <= tag_d;
         data_q   <= data_d;
         status_q <= status_d;
      end
   end

   assign s_ready   = (state_q == IDLE);
   assign fe_load   = (state_q == LOAD);
   assign fe_n      = n_q;
   assign m_valid   = (state_q == HOLD);
   assign m_data    = data_q;
   assign m_tag     = tag_q;
   assign m_ovf     = status_q.ovf;
   assign m_err     = status_q.err;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fact_job_ctrl.sv
// Self-checking bench for fact_job_ctrl with a behavioural engine stub and a
// reference model that predicts each response and its latency from n alone.
module tb_fact_job_ctrl;
   import fact_pkg::*;

   localparam int N_W     = 4;
   localparam int D_W     = 32;
   localparam int TAG_W   = 4;
   localparam int MAX_N   = 12;
   localparam int TIMEOUT = 32;
   localparam int EW      = D_W + TAG_W + 2;
   localparam int BUDGET  = 100;

   logic             clk = 1'b0;
   logic             rstn;
   logic             s_valid;
   logic             s_ready;
   logic [N_W-1:0]   s_n;
   logic [TAG_W-1:0] s_tag;
   logic             fe_load;
   logic [N_W-1:0]   fe_n;
   logic [D_W-1:0]   fe_data;
   logic             fe_valid;
   logic             m_valid;
   logic             m_ready;
   logic [D_W-1:0]   m_data;
   logic [TAG_W-1:0] m_tag;
   logic             m_ovf;
   logic             m_err;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   int            lat_q[$];

   // clock / reset
   always #5 clk = ~clk;

   fact_job_ctrl #(
      .N_W (N_W), .D_W (D_W), .TAG_W (TAG_W), .MAX_N (MAX_N), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_n       (s_n),
      .s_tag     (s_tag),
      .fe_load   (fe_load),
      .fe_n      (fe_n),
      .fe_data   (fe_data),
      .fe_valid  (fe_valid),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_tag     (m_tag),
      .m_ovf     (m_ovf),
      .m_err     (m_err),
      .dbg_state (dbg_state)
   );

   function automatic longint fact(input int n);
      longint r = 1;
      for (int i = 2; i <= n; i++) r = r * i;
      return r;
   endfunction

   // Engine stub: valid rises n edges after the edge that samples fe_load; garbage data before.
   logic           eng_hang = 1'b0;
   logic           eng_busy;
   logic [N_W-1:0] eng_left;
   logic [N_W-1:0] eng_n;

   always @(posedge clk) begin
      if (!rstn) begin
         fe_valid <= 1'b0;
         fe_data  <= '0;
         eng_busy <= 1'b0;
         eng_left <= '0;
         eng_n    <= '0;
      end else if (fe_load) begin
         fe_valid <= 1'b0;
         fe_data  <= $urandom;
         eng_busy <= !eng_hang;
         eng_left <= fe_n;
         eng_n    <= fe_n;
      end else if (eng_busy) begin
         fe_data  <= $urandom;
         eng_left <= eng_left - 1'b1;
         if (eng_left == 1) begin
            fe_valid <= 1'b1;
            fe_data  <= D_W'(fact(int'(eng_n)));
            eng_busy <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: response word {data, tag, ovf, err} and cycles from accept to m_valid.
   task automatic push_expect(input int n, input int tag, input bit hang);
      logic [D_W-1:0] d;
      logic           ovf;
      logic           err;
      int             lat;
      ovf = 1'b0;
      err = 1'b0;
      if (n == 0) begin
         d = D_W'(1);
         lat = 1;
      end else if (n > MAX_N) begin
         d = '0;
         ovf = 1'b1;
         lat = 1;
      end else if (hang) begin
         d = '0;
         err = 1'b1;
         lat = TIMEOUT + 2;
      end else begin
         d = D_W'(fact(n));
         lat = n + 3;
      end
      exp_q.push_back({d, TAG_W'(tag), ovf, err});
      lat_q.push_back(lat);
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_s_ready"}, s_ready, 1);
      chk({pfx, "_fe_load"}, fe_load, 0);
      chk({pfx, "_fe_n"}, fe_n, 0);
      chk({pfx, "_m_valid"}, m_valid, 0);
      chk({pfx, "_m_data"}, m_data, 0);
      chk({pfx, "_m_tag"}, m_tag, 0);
      chk({pfx, "_m_ovf"}, m_ovf, 0);
      chk({pfx, "_m_err"}, m_err, 0);
      chk({pfx, "_state"}, dbg_state, IDLE);
   endtask

   // driver: one complete job, including optional downstream back-pressure
   task automatic run_job(input int n, input int tag, input bit hang, input int delay);
      int            cyc;
      int            loads;
      int            load_cyc;
      int            load_n;
      int            busy_bad;
      int            hold_bad;
      int            exp_lat;
      logic [EW-1:0] exp_w;
      push_expect(n, tag, hang);
      cyc = 0;
      while (!s_ready && cyc < BUDGET) begin
         tick();
         cyc++;
      end
      chk("s_ready_before_req", s_ready, 1);
      eng_hang = hang;
      s_valid  = 1'b1;
      s_n      = N_W'(n);
      s_tag    = TAG_W'(tag);
      tick();
      s_valid = 1'b0;
      s_n     = N_W'($urandom);
      s_tag   = TAG_W'($urandom);
      cyc      = 1;
      loads    = 0;
      load_cyc = -1;
      load_n   = -1;
      busy_bad = 0;
      while (!m_valid && cyc < BUDGET) begin
         if (fe_load) begin
            loads++;
            load_cyc = cyc;
            load_n   = int'(fe_n);
         end
         if (s_ready) busy_bad++;
         tick();
         cyc++;
      end
      exp_w   = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      chk("m_valid_seen", m_valid, 1);
      chk("latency", cyc, exp_lat);
      chk("m_data", m_data, exp_w[EW-1 -: D_W]);
      chk("m_tag", m_tag, exp_w[TAG_W+1:2]);
      chk("m_ovf", m_ovf, exp_w[1]);
      chk("m_err", m_err, exp_w[0]);
      chk("s_ready_busy", busy_bad, 0);
      chk("s_ready_in_hold", s_ready, 0);
      if (n >= 1 && n <= MAX_N) begin
         chk("fe_load_count", loads, 1);
         chk("fe_load_cycle", load_cyc, 1);
         chk("fe_n", load_n, n);
      end else begin
         chk("fe_load_count_none", loads, 0);
      end
      hold_bad = 0;
      for (int i = 0; i < delay; i++) begin
         tick();
         if (!m_valid || s_ready || fe_load || m_data !== exp_w[EW-1 -: D_W] ||
             {m_tag, m_ovf, m_err} !== exp_w[TAG_W+1:0]) hold_bad++;
      end
      chk("hold_stable", hold_bad, 0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("m_valid_after_hs", m_valid, 0);
      chk("s_ready_after_hs", s_ready, 1);
   endtask

   initial begin
      int seen;
      rstn    = 1'b0;
      s_valid = 1'b0;
      s_n     = '0;
      s_tag   = '0;
      m_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rstn = 1'b1;
      tick();

      run_job(5, 3, 1'b0, 0);
      run_job(0, 7, 1'b0, 0);
      run_job(13, 1, 1'b0, 0);
      run_job(12, 2, 1'b0, 0);
      run_job(4, 5, 1'b1, 0);
      run_job(3, 6, 1'b0, 10);
      run_job(1, 8, 1'b0, 0);

      // reset during WAIT of n=10: job is dropped, block restarts cleanly
      eng_hang = 1'b0;
      s_valid  = 1'b1;
      s_n      = 4'd10;
      s_tag    = 4'd9;
      tick();
      s_valid = 1'b0;
      repeat (5) tick();
      chk("mid_wait_no_valid", m_valid, 0);
      rstn = 1'b0;
      tick();
      check_reset_outputs("midjob_reset");
      rstn = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_valid || fe_load) seen++;
      end
      chk("dropped_job_silent", seen, 0);
      run_job(2, 4, 1'b0, 0);

      for (int i = 0; i < 25; i++) begin
         run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fact_job_ctrl.md
# fact_job_ctrl

Job controller that sits directly upstream of the iterative factorial engine and drives it. It accepts factorial requests (n, tag) over a valid/ready handshake and pulses the engine's load strobe. It captures the engine's result when the engine's valid flag rises and returns the result downstream over a second valid/ready handshake. It handles the cases the engine cannot: n==0 (the engine never raises valid), n above the representable maximum, and an engine that never completes (watchdog timeout).

## Interface
Parameters:
- N_W, 4: request width of n; matches the engine's n port.
- D_W, 32: result width; matches the engine's data port.
- TAG_W, 4: opaque request tag, returned unchanged with the result.
- MAX_N, 12: largest n whose factorial fits in D_W bits.
- TIMEOUT, 32: maximum WAIT cycles before a job is aborted; must be > MAX_N+1.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  reset, synchronous, active-low.
- s_valid  in  1  request valid.
- s_ready  out  1  request ready.
- s_n  in  N_W  requested n.
- s_tag  in  TAG_W  request tag.
- fe_load  out  1  engine load strobe, one cycle wide.
- fe_n  out  N_W  n presented to the engine; held stable from LOAD until the next accept.
- fe_data  in  D_W  engine result.
- fe_valid  in  1  engine done flag; level, sticky until the next load.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_data  out  D_W  factorial result.
- m_tag  out  TAG_W  tag of the job.
- m_ovf  out  1  n > MAX_N; m_data is 0.
- m_err  out  1  watchdog timeout; m_data is 0.

## Operation
- FSM states: IDLE, LOAD, WAIT, HOLD.
- IDLE: s_ready=1. A request is accepted on s_valid&&s_ready. On accept, n and tag are latched and the next state is chosen:
  - n==0: go to HOLD with data=1, ovf=0, err=0. The engine is not loaded.
  - n>MAX_N: go to HOLD with data=0, ovf=1. The engine is not loaded.
  - Otherwise: go to LOAD.
- LOAD: fe_load=1 for exactly this cycle, fe_n=latched n. The watchdog counter is cleared. Next state is WAIT.
- WAIT: fe_valid is sampled every cycle.
  - fe_valid=1: fe_data is captured into the result register, then go to HOLD.
  - fe_valid=0: the counter increments. When the counter reaches TIMEOUT-1 with fe_valid still 0, go to HOLD with data=0, err=1.
  - fe_valid from a previous job is never observed, because the engine clears valid on the same edge that samples fe_load.
- HOLD: m_valid=1. m_data, m_tag, m_ovf and m_err are held stable until m_ready. On m_valid&&m_ready, go to IDLE.
- s_ready=0 in LOAD, WAIT and HOLD; there is no request overlap (one job in flight).
- m_ovf and m_err are mutually exclusive. Both are 0 on a normal result.
- Every output is driven from registered state. There are no combinational paths from s_valid or m_ready to any output.

## Timing
- Reset (rstn=0 at a clk edge): state=IDLE, counter=0, result/tag/flags=0, fe_n=0.
  - Output values after reset: s_ready=1, fe_load=0, m_valid=0, m_data=0, m_tag=0, m_ovf=0, m_err=0.
- Reset mid-job (any state): the job is discarded, no response is produced, and the block is back in IDLE on the next cycle. The engine shares rstn.
- Normal latency for 1≤n≤MAX_N, with the accept edge at cycle 0:
  - LOAD in cycle 1.
  - fe_valid first seen in WAIT cycle n+1, i.e. absolute cycle n+2.
  - m_valid from cycle n+3.
- n==0 or n>MAX_N: m_valid in cycle 1.
- Throughput: the next accept is possible in the cycle after the m_valid&&m_ready handshake.
- Downstream back-pressure (m_ready=0) holds HOLD indefinitely; the watchdog does not run in HOLD.

## Structure
- Shared package fact_pkg:
  - FACT_MAX_N = 12.
  - fact_state_e enum (IDLE, LOAD, WAIT, HOLD).
  - fact_status_t packed struct {ovf, err}.
  - These are reused by the engine bench and any other consumers.
- One sub-module: fact_watchdog.
  - Clear/enable inputs, a parameterised TIMEOUT, and a one-cycle expire output.
  - Counter width is $clog2(TIMEOUT).

## Test plan
- Reset, then n=5, tag=3, m_ready=1 → fe_load is high in cycle 1 only with fe_n=5; m_valid in cycle 8 with m_data=120, m_tag=3, ovf=0, err=0.
- n=0, tag=7 → fe_load is never asserted; m_valid in cycle 1 with m_data=1, m_tag=7.
- n=13 → m_valid in cycle 1 with m_data=0, m_ovf=1; n=12 → m_data=479001600, m_ovf=0.
- Engine stub holds fe_valid=0 after a load of n=4 → m_err=1 and m_data=0 after TIMEOUT WAIT cycles; s_ready returns after the handshake.
- n=3 with m_ready=0 for 10 cycles → m_valid and m_data=6 held stable, s_ready=0 throughout; accepted on m_ready=1; a back-to-back request of n=1 returns 1.
- rstn asserted during WAIT of n=10 → all outputs return to their reset values next cycle; no m_valid is produced for that job; a new request n=2 returns 2.
